// File: rtl/disp_pkg.sv
// Shared constants and font lookup for the 4-digit 7-segment scanner.
// All segment and select values are active-low.
package disp_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] SEL_OFF = 4'hF;

    // {dp,g,f,e,d,c,b,a} glyphs with dp off; entry 0 is the low byte
    localparam logic [15:0][7:0] FONT = {
        8'h8E, 8'h86, 8'hA1, 8'hC6,
        8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99,
        8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [7:0] hex_font(
        input logic [3:0] nibble,
        input logic       dp
    );
        return {~dp, FONT[nibble][6:0]};
    endfunction

endpackage

// File: rtl/disp_scan_if.sv
// Display word in, multiplexed digit/segment drive out.
interface disp_if;

    logic [15:0] number;
    logic [3:0]  dot;
    logic [3:0]  blank;
    logic [3:0]  sel;
    logic [7:0]  seg;

    modport master (
        output number, dot, blank,
        input  sel, seg
    );

    modport slave (
        input  number, dot, blank,
        output sel, seg
    );

endinterface

// File: rtl/disp_scan_hex7seg.sv
// Combinational nibble + decimal point to active-low segment pattern.
module hex7seg
    import disp_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    assign seg = hex_font(nibble, dp);

endmodule

// File: rtl/disp_scan.sv
// 4-digit scanned 7-segment driver with per-slot blanking gap and
// once-per-frame snapshot of the displayed word.
module disp_scan
    import disp_pkg::*;
#(
    parameter int TICK_DIV  = 12500,
    parameter int BLANK_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    disp_if.slave io
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   num_sh_q, num_sh_d;
    logic [3:0]    dot_sh_q, dot_sh_d;
    logic [3:0]    blank_sh_q, blank_sh_d;
    logic [3:0]    sel_q, sel_d;
    logic [7:0]    seg_q, seg_d;

    logic [3:0] nib;
    logic       nib_dp;
    logic [7:0] font_seg;

    hex7seg u_font (
        .nibble (nib),
        .dp     (nib_dp),
        .seg    (font_seg)
    );

    always_comb begin
        cnt_d      = cnt_q + CW'(1);
        idx_d      = idx_q;
        num_sh_d   = num_sh_q;
        dot_sh_d   = dot_sh_q;
        blank_sh_d = blank_sh_q;
        sel_d      = SEL_OFF;
        seg_d      = SEG_OFF;
        nib        = num_sh_q[{idx_q, 2'b00} +: 4];
        nib_dp     = dot_sh_q[idx_q];

        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end

        // Capture at the top of digit 0 so a frame never mixes two words
        if (cnt_q == '0 && idx_q == 2'd0) begin
            num_sh_d   = io.number;
            dot_sh_d   = io.dot;
            blank_sh_d = io.blank;
        end

        if (cnt_q >= BLANK_END) begin
            sel_d = ~(4'b0001 << idx_q);
            if (!blank_sh_q[idx_q]) seg_d = font_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= 2'd0;
            num_sh_q   <= '0;
            dot_sh_q   <= '0;
            blank_sh_q <= '0;
            sel_q      <= SEL_OFF;
            seg_q      <= SEG_OFF;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            num_sh_q   <= num_sh_d;
            dot_sh_q   <= dot_sh_d;
            blank_sh_q <= blank_sh_d;
            sel_q      <= sel_d;
            seg_q      <= seg_d;
        end
    end

    assign io.sel = sel_q;
    assign io.seg = seg_q;

endmodule

// File: tb/tb_disp_scan.sv
// Scoreboard bench for disp_scan: digit glyphs, dots/blank, anti-tear,
// slot timing, reset behaviour and a minimum-size parameter instance.
module tb_disp_scan;

    localparam logic [7:0] TFONT [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    disp_if d1 ();
    disp_if d2 ();

    disp_scan #(.TICK_DIV(16), .BLANK_CYC(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .io  (d1.slave)
    );

    disp_scan #(.TICK_DIV(3), .BLANK_CYC(1)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .io  (d2.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] obs_q [$];
    logic [11:0] exp_q [$];
    int          show_len_q [$];
    int          gap_len_q [$];

    logic       mon_en   = 1'b0;
    logic [3:0] prev_sel = 4'hF;
    int         run      = 0;
    int         n_frame  = 0;
    int         multi_bad = 0;
    int         off_bad   = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if ($countones(~d1.sel) > 1) multi_bad++;
            if (d1.sel == 4'hF && d1.seg !== 8'hFF) off_bad++;
            if (d1.sel != 4'hF && prev_sel == 4'hF) begin
                obs_q.push_back({d1.sel, d1.seg});
                gap_len_q.push_back(run);
                run = 1;
            end else if (d1.sel == 4'hF && prev_sel != 4'hF) begin
                show_len_q.push_back(run);
                run = 1;
                if (prev_sel == 4'h7) n_frame++;
            end else begin
                run++;
            end
            prev_sel = d1.sel;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_tests++;
        n_fail++;
        $error("FAIL %s: timed out waiting for DUT", tag);
    endtask

    task automatic sync_frame();
        int n0;
        @(posedge clk);
        n0 = n_frame;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (n_frame != n0) break;
        end
        if (n_frame == n0) timeout("sync");
        obs_q.delete();
        show_len_q.delete();
        gap_len_q.delete();
    endtask

    task automatic check_n(input string tag, input int n);
        for (int i = 0; i < 100 * n; i++) begin
            if (obs_q.size() >= n) break;
            @(negedge clk);
        end
        if (obs_q.size() < n) timeout(tag);
        for (int i = 0; i < n; i++) begin
            if (obs_q.size() == 0 || exp_q.size() == 0) break;
            chk(tag, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
        end
        exp_q.delete();
    endtask

    task automatic push_dig(input int i, input logic [7:0] seg);
        logic [3:0] s;
        s = ~(4'b0001 << i);
        exp_q.push_back({s, seg});
    endtask

    initial begin
        int k;
        d1.number = 16'h0000;
        d1.dot    = 4'h0;
        d1.blank  = 4'h0;
        d2.number = 16'h3210;
        d2.dot    = 4'h0;
        d2.blank  = 4'h0;

        repeat (3) @(negedge clk);
        chk("rst_sel", 32'(d1.sel), 32'hF);
        chk("rst_seg", 32'(d1.seg), 32'hFF);
        chk("rst_sel2", 32'(d2.sel), 32'hF);
        chk("rst_seg2", 32'(d2.seg), 32'hFF);
        rst    = 1'b0;
        mon_en = 1'b1;

        // minimum slot: 3 cycles, 1 blank -> 2-cycle SHOW per digit
        for (int e = 1; e <= 24; e++) begin
            int c;
            int i;
            logic [11:0] ex;
            @(negedge clk);
            c  = (e - 1) % 3;
            i  = ((e - 1) / 3) % 4;
            ex = (c >= 1) ? {~(4'b0001 << i), TFONT[i]} : 12'hFFF;
            chk("edge_seq", 32'({d2.sel, d2.seg}), 32'(ex));
        end

        for (int f = 0; f < 4; f++) begin
            d1.number = {4'(4*f+3), 4'(4*f+2), 4'(4*f+1), 4'(4*f)};
            for (int i = 0; i < 4; i++) push_dig(i, TFONT[4*f+i]);
            sync_frame();
            check_n("font", 4);
        end

        d1.number = 16'h8888;
        d1.dot    = 4'b0101;
        d1.blank  = 4'b1000;
        push_dig(0, 8'h00);
        push_dig(1, 8'h80);
        push_dig(2, 8'h00);
        push_dig(3, 8'hFF);
        sync_frame();
        check_n("dot_blank", 4);

        d1.number = 16'h1234;
        d1.dot    = 4'h0;
        d1.blank  = 4'h0;
        push_dig(0, 8'h99);
        push_dig(1, 8'hB0);
        push_dig(2, 8'hA4);
        push_dig(3, 8'hF9);
        push_dig(0, 8'hA1);
        push_dig(1, 8'hC6);
        push_dig(2, 8'h83);
        push_dig(3, 8'h88);
        sync_frame();
        for (int i = 0; i < 300; i++) begin
            if (obs_q.size() >= 3) break;
            @(negedge clk);
        end
        if (obs_q.size() < 3) timeout("tear_wait");
        d1.number = 16'hABCD;
        check_n("tear", 8);

        d1.number = 16'h5A5A;
        sync_frame();
        for (int i = 0; i < 1000; i++) begin
            if (show_len_q.size() >= 40) break;
            @(negedge clk);
        end
        if (show_len_q.size() < 40) timeout("period");
        for (int i = 0; i < 40; i++) begin
            if (show_len_q.size() == 0 || gap_len_q.size() == 0) break;
            chk("show_len", 32'(show_len_q.pop_front()), 32'd12);
            chk("gap_len", 32'(gap_len_q.pop_front()), 32'd4);
        end
        chk("one_sel", 32'(multi_bad), 32'd0);
        chk("off_seg", 32'(off_bad), 32'd0);

        for (int i = 0; i < 100; i++) begin
            if (d1.sel != 4'hF) break;
            @(negedge clk);
        end
        if (d1.sel == 4'hF) timeout("show_wait");
        rst       = 1'b1;
        d1.number = 16'h00C5;
        d1.dot    = 4'b0001;
        @(negedge clk);
        chk("mid_rst", 32'({d1.sel, d1.seg}), 32'hFFF);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            k++;
            if (d1.sel != 4'hF) break;
        end
        chk("rst_lat", 32'(k), 32'd5);
        chk("rst_dig0", 32'({d1.sel, d1.seg}), 32'hE12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
